// File: rtl/mux_sequencer_if.sv
// Step-request and address bundle between a step source and mux_sequencer.
// Widths derive from the same parameters as the sequencer.
interface mux_sequencer_if #(
    parameter int ADDR_W   = 3,
    parameter int N_GROUPS = 2,
    parameter int N_FUNC   = 3
);
    localparam int CNT_W = $clog2(N_GROUPS * (2 ** ADDR_W) + 2);
    localparam int FI_W  = (N_FUNC > 1) ? $clog2(N_FUNC) : 1;

    logic              switchSignal;
    logic              en;
    logic              restart;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [CNT_W-1:0]  cntChannel;
    logic [FI_W-1:0]   func_idx;
    logic              frame_start;
    logic              sample_strobe;
    logic              busy;

    modport master (
        output switchSignal, en, restart,
        input  addr_a, addr_b, cntChannel, func_idx,
        input  frame_start, sample_strobe, busy
    );

    modport slave (
        input  switchSignal, en, restart,
        output addr_a, addr_b, cntChannel, func_idx,
        output frame_start, sample_strobe, busy
    );
endinterface

// File: rtl/mux_sequencer.sv
// Analog-mux channel sequencer: data slots, one rotating function slot,
// a park slot, then a settle timer ending in a one-cycle sample strobe.
module mux_sequencer #(
    parameter int                         ADDR_W     = 3,
    parameter int                         N_GROUPS   = 2,
    parameter int                         N_FUNC     = 3,
    parameter logic [N_FUNC*ADDR_W-1:0]   FUNC_SEL   = {3'd5, 3'd3, 3'd2},
    parameter logic [ADDR_W-1:0]          IDLE_SEL   = 3'd4,
    parameter int                         SETTLE_CYC = 4
) (
    input logic            clk,
    input logic            reset,
    mux_sequencer_if.slave bus
);
    localparam int S     = N_GROUPS * (2 ** ADDR_W);
    localparam int LAST  = S + 1;
    localparam int CNT_W = $clog2(S + 2);
    localparam int FI_W  = (N_FUNC > 1) ? $clog2(N_FUNC) : 1;
    localparam int SC_W  = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;

    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LAST);
    localparam logic [CNT_W-1:0] S_C    = CNT_W'(S);
    localparam logic [FI_W-1:0]  FI_TOP = FI_W'(N_FUNC - 1);
    localparam logic [SC_W-1:0]  SC_LD  = SC_W'(SETTLE_CYC);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    state_t            state;
    logic [SC_W-1:0]   settle;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [FI_W-1:0]   func_idx;
    logic              frame_start;
    logic              sample_strobe;
    logic              busy;
    logic [CNT_W-1:0]  nxt;

    assign nxt = (cnt == LAST_C) ? '0 : cnt + 1'b1;

    always_ff @(posedge clk) begin
        // Restart shares the park values with reset, but only loses to it.
        if (!reset || bus.restart) begin
            state         <= IDLE;
            settle        <= '0;
            cnt           <= LAST_C;
            addr_a        <= '0;
            addr_b        <= IDLE_SEL;
            func_idx      <= '0;
            frame_start   <= 1'b0;
            sample_strobe <= 1'b0;
            busy          <= 1'b0;
        end else begin
            frame_start   <= 1'b0;
            sample_strobe <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.en && bus.switchSignal) begin
                        state       <= SETTLE;
                        settle      <= SC_LD;
                        busy        <= 1'b1;
                        cnt         <= nxt;
                        frame_start <= (nxt == '0);
                        if (nxt < S_C) begin
                            addr_a <= ADDR_W'(nxt);
                            addr_b <= ADDR_W'(nxt >> ADDR_W);
                        end else if (nxt == S_C) begin
                            addr_a   <= '0;
                            addr_b   <= FUNC_SEL[int'(func_idx)*ADDR_W +: ADDR_W];
                            func_idx <= (func_idx == FI_TOP) ? '0 : func_idx + 1'b1;
                        end else begin
                            addr_a <= '0;
                            addr_b <= IDLE_SEL;
                        end
                    end
                end
                SETTLE: begin
                    if (settle == '0) begin
                        sample_strobe <= 1'b1;
                        state         <= HOLD;
                    end else begin
                        settle <= settle - 1'b1;
                    end
                end
                HOLD: begin
                    // One step per high level of the request.
                    if (!bus.switchSignal) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.addr_a        = addr_a;
    assign bus.addr_b        = addr_b;
    assign bus.cntChannel    = cnt;
    assign bus.func_idx      = func_idx;
    assign bus.frame_start   = frame_start;
    assign bus.sample_strobe = sample_strobe;
    assign bus.busy          = busy;
endmodule

// File: doc/mux_sequencer.md
# mux_sequencer

Parametrised analog-multiplexer channel sequencer for the telemetry front end. Each rising step request advances a frame slot and drives the shared first-stage address and the second-stage address. A frame scans every data channel, then one rotating function channel, then a park slot. Each step ends with a settle timer and a one-cycle `sample_strobe` for the ADC capture logic. Unlike the single fixed 8+8+1+1 switcher, this block adds group count, function-table size, settle delay, an enable and a synchronous frame restart as parameters or controls.

## Interface
Parameters:
- `ADDR_W`, 3: address bits per mux chip. Each group has 2^ADDR_W channels.
- `N_GROUPS`, 2: number of first-stage muxes feeding the second stage, on second-stage inputs 0..N_GROUPS-1.
- `N_FUNC`, 3: number of rotating function channels (≥1).
- `FUNC_SEL`, {3'd5,3'd3,3'd2}: packed N_FUNC×ADDR_W table of second-stage addresses. Entry 0 is in the LSBs.
- `IDLE_SEL`, 3'd4: second-stage address for the park slot.
- `SETTLE_CYC`, 4: settle cycles after an address change, before the strobe.
- Derived localparams: S = N_GROUPS·2^ADDR_W; LAST = S+1; CNT_W = clog2(S+2), which is 5 at the defaults.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-low reset.
- `switchSignal` in 1: step request, level-held. It is already synchronous to `clk`.
- `en` in 1: step enable.
- `restart` in 1: synchronous frame restart, one-cycle pulse.
- `addr_a` out ADDR_W: first-stage address, shared by all first-stage muxes.
- `addr_b` out ADDR_W: second-stage address.
- `cntChannel` out CNT_W: index of the slot currently presented, in 0..LAST.
- `func_idx` out clog2(N_FUNC) (min 1): function-table index the next function slot will use.
- `frame_start` out 1: one-cycle pulse when slot 0 is presented.
- `sample_strobe` out 1: one-cycle pulse when the presented slot has settled.
- `busy` out 1: high while in SETTLE or HOLD.

## Operation
- Reset (reset=0 at a clock edge) puts the block in park:
  - state=IDLE, cntChannel=LAST, addr_a=0, addr_b=IDLE_SEL, func_idx=0.
  - frame_start=0, sample_strobe=0, busy=0, settle counter=0.
- State machine:
  - IDLE: if en=1 and switchSignal=1, perform a step and go to SETTLE. Otherwise stay.
  - SETTLE: if the counter is 0, set sample_strobe for one cycle and go to HOLD. Otherwise decrement.
  - HOLD: if switchSignal=0, go to IDLE. One step per high level, as in the existing switcher.
- A step sets next = (cntChannel==LAST) ? 0 : cntChannel+1. It then registers all of the following at the same edge:
  - cntChannel=next.
  - Settle counter=SETTLE_CYC.
  - frame_start = (next==0).
  - Addresses, by slot:
    - next<S (data slot): addr_a=next[ADDR_W-1:0], addr_b=next>>ADDR_W.
    - next==S (function slot): addr_a=0, addr_b=FUNC_SEL[func_idx]. func_idx then increments, wrapping N_FUNC-1→0.
    - next==LAST (park slot): addr_a=0, addr_b=IDLE_SEL.
- Arithmetic:
  - cntChannel never exceeds LAST and never wraps through unused codes.
  - Address fields are truncated or zero-extended to ADDR_W.
- en=0 only blocks new steps in IDLE. A step already in SETTLE or HOLD completes normally.
- restart=1 forces the park values (cntChannel=LAST, addr_b=IDLE_SEL, addr_a=0, func_idx=0, state IDLE) and kills any pending strobe. The next step therefore presents slot 0.
- Priority: reset > restart > step.
- switchSignal falling during SETTLE does not shorten settling. HOLD then exits on the first cycle it sees switchSignal=0.
- Collisions between FUNC_SEL/IDLE_SEL and group indices 0..N_GROUPS-1 are not checked. Keeping them distinct is the integrator's duty.

## Timing
- Step edge E is the edge where IDLE samples en=1 and switchSignal=1.
- Addresses, cntChannel, func_idx and frame_start are valid from E.
- sample_strobe is high for exactly the cycle following edge E+SETTLE_CYC+1. With SETTLE_CYC=0, it follows E+1.
- busy rises at E and falls at the edge where HOLD sees switchSignal=0.
- Minimum step period is SETTLE_CYC+3 cycles: 1 IDLE cycle, SETTLE_CYC+1 SETTLE cycles, and at least 1 HOLD cycle with switchSignal low.
- All outputs are registered. There are no combinational paths from inputs.

## Test plan
- Reset, then 18 step pulses at default parameters:
  - cntChannel runs 0..17.
  - addr_a/addr_b run 0/0 … 7/0, then 0/1 … 7/1, then 0/2 (function slot), then 0/4 (park).
  - frame_start pulses at step 1 only.
- Three full frames: function-slot addr_b sequence is 2, 3, 5. A fourth frame returns to 2, and func_idx reads 0 before it.
- Settle timing with SETTLE_CYC=4, switchSignal held high for 20 cycles:
  - Exactly one sample_strobe, 5 cycles after E.
  - No second step until switchSignal has been low for at least one cycle.
- en=0 while switchSignal toggles 5 times: no change in cntChannel or addresses. Dropping en during SETTLE still yields the strobe.
- restart mid-frame at cntChannel=9:
  - Park values are restored and no strobe follows.
  - The next step gives cntChannel=0, addr 0/0, frame_start=1.
  - restart coinciding with a step edge: restart wins.
- Parameter sweep ADDR_W=2, N_GROUPS=3, N_FUNC=1, SETTLE_CYC=0:
  - Frame length is 14 slots, and the function slot always uses FUNC_SEL[0].
  - The strobe follows E+1, and synchronous reset mid-SETTLE returns all outputs to park values.
